// File: rtl/sys_bridge_pkg.sv
// Shared types and address map for the M-stage device bridge.
// The address bounds are inclusive byte ranges of the memory-mapped devices.
package sys_bridge_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCESS = 2'd1,
      ST_DONE   = 2'd2
   } state_t;

   typedef struct packed {
      logic key;
      logic disp;
      logic led;
      logic sw;
      logic uart;
      logic timer;
   } dev_sel_t;

   localparam logic [31:0] TIMER_BEGIN  = 32'h0000_7F00;
   localparam logic [31:0] TIMER_END    = 32'h0000_7F0B;
   localparam logic [31:0] TIMER_COUNT  = 32'h0000_7F08;
   localparam logic [31:0] UART_BEGIN   = 32'h0000_7F10;
   localparam logic [31:0] UART_END     = 32'h0000_7F2B;
   localparam logic [31:0] SWITCH_BEGIN = 32'h0000_7F2C;
   localparam logic [31:0] SWITCH_END   = 32'h0000_7F33;
   localparam logic [31:0] LED_BEGIN    = 32'h0000_7F34;
   localparam logic [31:0] LED_END      = 32'h0000_7F37;
   localparam logic [31:0] DISP_BEGIN   = 32'h0000_7F38;
   localparam logic [31:0] DISP_END     = 32'h0000_7F3F;
   localparam logic [31:0] KEY_BEGIN    = 32'h0000_7F40;
   localparam logic [31:0] KEY_END      = 32'h0000_7F43;

   function automatic logic in_range(input logic [31:0] addr,
                                     input logic [31:0] lo,
                                     input logic [31:0] hi);
      return (addr >= lo) && (addr <= hi);
   endfunction

endpackage

// File: rtl/bridge_decode.sv
// Combinational address decoder: byte address to one-hot device select plus hit flag.
module bridge_decode
   import sys_bridge_pkg::*;
(
   input  logic [31:0] addr,
   output dev_sel_t    sel,
   output logic        hit
);

   always_comb begin
      sel.timer = in_range(addr, TIMER_BEGIN,  TIMER_END);
      sel.uart  = in_range(addr, UART_BEGIN,   UART_END);
      sel.sw    = in_range(addr, SWITCH_BEGIN, SWITCH_END);
      sel.led   = in_range(addr, LED_BEGIN,    LED_END);
      sel.disp  = in_range(addr, DISP_BEGIN,   DISP_END);
      sel.key   = in_range(addr, KEY_BEGIN,    KEY_END);
   end

   assign hit = |sel;

endmodule

// File: rtl/sys_bridge.sv
// CPU data-bus responder for the memory-mapped devices: latches one access, strobes the
// device, returns registered read data with a one-cycle ready pulse, and registers irqs.
module sys_bridge
   import sys_bridge_pkg::*;
#(
   parameter int TIMEOUT = 16,
   parameter int CNT_W   = 5
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        cpu_req,
   input  logic        cpu_we,
   input  logic [31:0] cpu_addr,
   input  logic [31:0] cpu_wdata,
   output logic [31:0] cpu_rdata,
   output logic        cpu_ready,
   output logic        cpu_stall,
   output logic        cpu_berr,
   output logic [31:0] dev_addr,
   output logic [31:0] dev_wdata,
   output logic        timer_we,
   output logic        led_we,
   output logic        disp_we,
   output logic        uart_stb,
   output logic        uart_we,
   input  logic        uart_ack,
   input  logic [31:0] timer_rdata,
   input  logic [31:0] uart_rdata,
   input  logic [31:0] switch_rdata,
   input  logic [31:0] led_rdata,
   input  logic [31:0] disp_rdata,
   input  logic [31:0] key_rdata,
   input  logic        timer_irq,
   input  logic        uart_irq,
   input  logic        key_irq,
   output logic [5:0]  hw_int
);

   state_t          state, state_n;
   dev_sel_t        sel, sel_q;
   logic            hit;
   logic [31:0]     addr_q, wdata_q, rdata_q, dev_rdata;
   logic            we_q, berr_q, timeout;
   logic [CNT_W-1:0] cnt_q;

   bridge_decode u_decode (
      .addr (cpu_addr),
      .sel  (sel),
      .hit  (hit)
   );

   // Device read mux driven only by the latched select; uart data is taken on ack instead.
   assign dev_rdata = ({32{sel_q.timer}} & timer_rdata)
                    | ({32{sel_q.sw}}    & switch_rdata)
                    | ({32{sel_q.led}}   & led_rdata)
                    | ({32{sel_q.disp}}  & disp_rdata)
                    | ({32{sel_q.key}}   & key_rdata);

   assign timeout   = (cnt_q == CNT_W'(TIMEOUT - 1));
   assign dev_addr  = addr_q;
   assign dev_wdata = wdata_q;
   assign cpu_stall = cpu_req & ~cpu_ready;

   always_ff @(posedge clk) begin
      // NOTE: non-blocking assignments make every register sample pre-edge values, whatever the statement order.
      if (reset) state <= ST_IDLE;
      else       state <= state_n;
   end

   always_comb begin
      // NOTE: every signal written here gets a default first, so no branch can infer a latch.
      state_n   = state;
      timer_we  = 1'b0;
      led_we    = 1'b0;
      disp_we   = 1'b0;
      uart_stb  = 1'b0;
      uart_we   = 1'b0;
      cpu_ready = 1'b0;
      cpu_rdata = '0;
      cpu_berr  = 1'b0;
      unique case (state)
         ST_IDLE: begin
            if (cpu_req) state_n = hit ? ST_ACCESS : ST_DONE;
         end
         ST_ACCESS: begin
            // Timer count register is read-only; switch and key have no write strobe.
            timer_we = sel_q.timer & we_q & (addr_q != TIMER_COUNT);
            led_we   = sel_q.led  & we_q;
            disp_we  = sel_q.disp & we_q;
            uart_stb = sel_q.uart;
            uart_we  = sel_q.uart & we_q;
            if (!sel_q.uart || uart_ack || timeout) state_n = ST_DONE;
         end
         ST_DONE: begin
            cpu_ready = 1'b1;
            cpu_rdata = rdata_q;
            cpu_berr  = berr_q;
            state_n   = ST_IDLE;
         end
         default: state_n = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         addr_q  <= '0;
         wdata_q <= '0;
         we_q    <= 1'b0;
         sel_q   <= '0;
         rdata_q <= '0;
         berr_q  <= 1'b0;
         cnt_q   <= '0;
      end else begin
         unique case (state)
            ST_IDLE: begin
               if (cpu_req) begin
                  addr_q  <= cpu_addr;
                  wdata_q <= cpu_wdata;
                  we_q    <= cpu_we;
                  sel_q   <= sel;
                  berr_q  <= ~hit;
                  rdata_q <= '0;
               end
            end
            ST_ACCESS: begin
               if (!sel_q.uart) begin
                  rdata_q <= we_q ? '0 : dev_rdata;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
                  // An ack in the timeout cycle still completes the access cleanly.
                  if (uart_ack) begin
                     rdata_q <= uart_rdata;
                  end else if (timeout) begin
                     berr_q  <= 1'b1;
                     rdata_q <= '0;
                  end
               end
            end
            ST_DONE: cnt_q <= '0;
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) hw_int <= '0;
      else       hw_int <= {3'b000, key_irq, uart_irq, timer_irq};
   end

endmodule

// File: tb/tb_sys_bridge.sv
// Self-checking bench for sys_bridge: a transaction-level model schedules the expected
// outputs of every cycle, and one compare process checks them at each falling edge.
module tb_sys_bridge;

   localparam int TIMEOUT = 16;
   localparam logic [31:0] LO   [6] = '{32'h7F00, 32'h7F10, 32'h7F2C, 32'h7F34, 32'h7F38, 32'h7F40};
   localparam logic [31:0] HI   [6] = '{32'h7F0B, 32'h7F2B, 32'h7F33, 32'h7F37, 32'h7F3F, 32'h7F43};
   localparam logic [31:0] MISS [6] = '{32'h7F0C, 32'h7F44, 32'h7EFC, 32'h0001_7F00, 32'h7F50, 32'h0};

   logic        clk = 1'b0, reset = 1'b1;
   logic        cpu_req = 1'b0, cpu_we = 1'b0;
   logic [31:0] cpu_addr = '0, cpu_wdata = '0;
   logic [31:0] cpu_rdata, dev_addr, dev_wdata;
   logic        cpu_ready, cpu_stall, cpu_berr;
   logic        timer_we, led_we, disp_we, uart_stb, uart_we;
   logic        uart_ack = 1'b0;
   logic [31:0] timer_rdata = '0, uart_rdata = '0, switch_rdata = '0;
   logic [31:0] led_rdata = '0, disp_rdata = '0, key_rdata = '0;
   logic        timer_irq = 1'b0, uart_irq = 1'b0, key_irq = 1'b0;
   logic [5:0]  hw_int;

   sys_bridge #(.TIMEOUT(TIMEOUT), .CNT_W(5)) dut (
      .clk(clk), .reset(reset),
      .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
      .cpu_rdata(cpu_rdata), .cpu_ready(cpu_ready), .cpu_stall(cpu_stall), .cpu_berr(cpu_berr),
      .dev_addr(dev_addr), .dev_wdata(dev_wdata),
      .timer_we(timer_we), .led_we(led_we), .disp_we(disp_we),
      .uart_stb(uart_stb), .uart_we(uart_we), .uart_ack(uart_ack),
      .timer_rdata(timer_rdata), .uart_rdata(uart_rdata), .switch_rdata(switch_rdata),
      .led_rdata(led_rdata), .disp_rdata(disp_rdata), .key_rdata(key_rdata),
      .timer_irq(timer_irq), .uart_irq(uart_irq), .key_irq(key_irq),
      .hw_int(hw_int)
   );

   always #5 clk = ~clk;

   int total = 0, bad = 0;
   bit chk_en = 0, rand_irq = 0, fixed_rd = 0;

   // expected outputs for the current cycle
   logic        exp_ready = 0, exp_berr = 0;
   logic [31:0] exp_rdata = '0, exp_dev_addr = '0, exp_dev_wdata = '0;
   logic        exp_twe = 0, exp_lwe = 0, exp_dwe = 0, exp_stb = 0, exp_uwe = 0;
   logic [5:0]  exp_hw_int = '0, last_irq = '0;
   logic [31:0] model_addr = '0, model_wdata = '0;

   // observation counters used by the literal checks
   int cyc = 0, req_cyc = 0, ready_cyc = 0;
   int we_cnt = 0, stb_cnt = 0, stall_cnt = 0, ready_cnt = 0;
   logic [31:0] rdata_seen = '0, wd_seen = '0;
   logic        berr_seen = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         check("cpu_ready", 32'(cpu_ready), 32'(exp_ready));
         check("cpu_rdata", cpu_rdata, exp_rdata);
         check("cpu_berr",  32'(cpu_berr),  32'(exp_berr));
         check("cpu_stall", 32'(cpu_stall), 32'(cpu_req & ~exp_ready));
         check("timer_we",  32'(timer_we),  32'(exp_twe));
         check("led_we",    32'(led_we),    32'(exp_lwe));
         check("disp_we",   32'(disp_we),   32'(exp_dwe));
         check("uart_stb",  32'(uart_stb),  32'(exp_stb));
         check("uart_we",   32'(uart_we),   32'(exp_uwe));
         check("dev_addr",  dev_addr,  exp_dev_addr);
         check("dev_wdata", dev_wdata, exp_dev_wdata);
         check("hw_int",    32'(hw_int),    32'(exp_hw_int));
      end
   end

   always @(negedge clk) begin
      cyc <= cyc + 1;
      if (chk_en) begin
         if (timer_we | led_we | disp_we) begin
            we_cnt  <= we_cnt + 1;
            wd_seen <= dev_wdata;
         end
         if (uart_stb)  stb_cnt   <= stb_cnt + 1;
         if (cpu_stall) stall_cnt <= stall_cnt + 1;
         if (cpu_ready) begin
            ready_cnt  <= ready_cnt + 1;
            ready_cyc  <= cyc + 1;
            rdata_seen <= cpu_rdata;
            berr_seen  <= cpu_berr;
         end
      end
   end

   task automatic clr_mon();
      we_cnt = 0; stb_cnt = 0; stall_cnt = 0; ready_cnt = 0;
      ready_cyc = 0; rdata_seen = '0; wd_seen = '0; berr_seen = 0;
   endtask

   function automatic int dev_of(input logic [31:0] a);
      for (int i = 0; i < 6; i++)
         if (a >= LO[i] && a <= HI[i]) return i;
      return -1;
   endfunction

   function automatic logic [31:0] rd_of(input int d);
      case (d)
         0: return timer_rdata;
         1: return uart_rdata;
         2: return switch_rdata;
         3: return led_rdata;
         4: return disp_rdata;
         default: return key_rdata;
      endcase
   endfunction

   task automatic set_exp(input logic rdy, input logic [31:0] rd, input logic be,
                          input logic twe, input logic lwe, input logic dwe,
                          input logic stb, input logic uwe);
      exp_ready = rdy; exp_rdata = rd; exp_berr = be;
      exp_twe = twe; exp_lwe = lwe; exp_dwe = dwe; exp_stb = stb; exp_uwe = uwe;
      exp_dev_addr = model_addr; exp_dev_wdata = model_wdata;
   endtask

   // Advance one clock: irqs seen at the edge appear on hw_int in the next cycle.
   task automatic step();
      @(posedge clk);
      last_irq = reset ? 6'b0 : {3'b000, key_irq, uart_irq, timer_irq};
      #1;
      exp_hw_int = last_irq;
      if (rand_irq) {key_irq, uart_irq, timer_irq} = 3'($urandom);
   endtask

   // Garbage on the cpu side after the request cycle must not disturb the access.
   task automatic scramble(input bit flush);
      cpu_req   = ~flush;
      cpu_addr  = $urandom;
      cpu_we    = 1'($urandom);
      cpu_wdata = $urandom;
      uart_ack  = 1'($urandom);
   endtask

   task automatic idle_cycles(input int n);
      for (int i = 0; i < n; i++) begin
         cpu_req   = 1'b0;
         cpu_addr  = $urandom;
         cpu_wdata = $urandom;
         uart_ack  = 1'($urandom);
         set_exp(0, '0, 0, 0, 0, 0, 0, 0);
         step();
      end
   endtask

   // ack_d: ACCESS cycle (1-based) carrying uart_ack, > TIMEOUT means never.
   // rst_at: uart ACCESS cycle in which reset is asserted, 0 means never.
   task automatic do_txn(input logic [31:0] addr, input logic we, input logic [31:0] wdata,
                         input int ack_d, input bit flush, input int rst_at);
      int  d, n;
      bit  acked, aborted;
      d = dev_of(addr);
      if (!fixed_rd) begin
         timer_rdata = $urandom; uart_rdata = $urandom; switch_rdata = $urandom;
         led_rdata = $urandom; disp_rdata = $urandom; key_rdata = $urandom;
      end
      cpu_req = 1'b1; cpu_addr = addr; cpu_we = we; cpu_wdata = wdata; uart_ack = 1'b0;
      req_cyc = cyc + 1;
      set_exp(0, '0, 0, 0, 0, 0, 0, 0);
      step();
      model_addr = addr;
      model_wdata = wdata;
      if (d < 0) begin
         scramble(flush);
         set_exp(1, '0, 1, 0, 0, 0, 0, 0);
         step();
      end else if (d != 1) begin
         scramble(flush);
         set_exp(0, '0, 0, (d == 0) && we && (addr != 32'h7F08), (d == 3) && we,
                 (d == 4) && we, 0, 0);
         step();
         scramble(flush);
         set_exp(1, we ? 32'h0 : rd_of(d), 0, 0, 0, 0, 0, 0);
         step();
      end else begin
         n = (ack_d <= TIMEOUT) ? ack_d : TIMEOUT;
         aborted = 0;
         for (int k = 1; k <= n && !aborted; k++) begin
            scramble(flush);
            uart_ack = (k == ack_d);
            reset    = (k == rst_at);
            set_exp(0, '0, 0, 0, 0, 0, 1, we);
            step();
            if (reset) begin
               reset = 1'b0;
               aborted = 1;
               model_addr = '0;
               model_wdata = '0;
            end
         end
         if (!aborted) begin
            scramble(flush);
            uart_ack = 1'b0;
            acked = (ack_d <= TIMEOUT);
            set_exp(1, acked ? uart_rdata : 32'h0, !acked, 0, 0, 0, 0, 0);
            step();
         end
      end
      uart_ack = 1'b0;
   endtask

   function automatic logic [31:0] gen_addr();
      int r;
      r = $urandom_range(0, 8);
      if (r < 6) return LO[r] + 32'(4 * $urandom_range(0, (HI[r] - LO[r]) / 4));
      return MISS[$urandom_range(0, 5)];
   endfunction

   initial begin
      set_exp(0, '0, 0, 0, 0, 0, 0, 0);
      step();
      chk_en = 1;
      step();
      check("rst_ready", 32'(cpu_ready), 32'h0);
      check("rst_stb", 32'(uart_stb), 32'h0);
      check("rst_hw_int", 32'(hw_int), 32'h0);
      check("rst_dev_addr", dev_addr, 32'h0);
      reset = 1'b0;
      idle_cycles(2);

      // 1: store to timer
      clr_mon();
      do_txn(32'h7F00, 1'b1, 32'h1234, 0, 0, 0);
      idle_cycles(1);
      check("t1_we_cycles", 32'(we_cnt), 32'd1);
      check("t1_wdata", wd_seen, 32'h1234);
      check("t1_latency", 32'(ready_cyc - req_cyc), 32'd2);
      check("t1_berr", 32'(berr_seen), 32'h0);

      // 2: load from switch
      fixed_rd = 1;
      switch_rdata = 32'hA5A5_0F0F;
      clr_mon();
      do_txn(32'h7F2C, 1'b0, 32'h0, 0, 0, 0);
      idle_cycles(1);
      check("t2_rdata", rdata_seen, 32'hA5A5_0F0F);
      check("t2_stall_cycles", 32'(stall_cnt), 32'd2);

      // 3: uart load, ack in the third ACCESS cycle
      uart_rdata = 32'h41;
      clr_mon();
      do_txn(32'h7F10, 1'b0, 32'h0, 3, 0, 0);
      idle_cycles(1);
      check("t3_stb_cycles", 32'(stb_cnt), 32'd3);
      check("t3_rdata", rdata_seen, 32'h41);
      check("t3_latency", 32'(ready_cyc - req_cyc), 32'd4);

      // 4: uart store timeout, then ack exactly in the last allowed cycle
      clr_mon();
      do_txn(32'h7F14, 1'b1, 32'hDEAD_BEEF, 99, 0, 0);
      idle_cycles(1);
      check("t4_stb_cycles", 32'(stb_cnt), 32'd16);
      check("t4_berr", 32'(berr_seen), 32'h1);
      check("t4_rdata", rdata_seen, 32'h0);
      check("t4_latency", 32'(ready_cyc - req_cyc), 32'd17);
      clr_mon();
      do_txn(32'h7F10, 1'b0, 32'h0, 16, 0, 0);
      idle_cycles(1);
      check("t4b_berr", 32'(berr_seen), 32'h0);
      check("t4b_rdata", rdata_seen, 32'h41);

      // 5: unmapped load
      clr_mon();
      do_txn(32'h7F50, 1'b0, 32'h0, 0, 0, 0);
      idle_cycles(1);
      check("t5_latency", 32'(ready_cyc - req_cyc), 32'd1);
      check("t5_berr", 32'(berr_seen), 32'h1);
      check("t5_strobes", 32'(we_cnt + stb_cnt), 32'd0);
      fixed_rd = 0;

      // 6: reset in the third uart ACCESS cycle, then an irq
      clr_mon();
      do_txn(32'h7F18, 1'b1, 32'h5555_AAAA, 99, 0, 3);
      idle_cycles(3);
      check("t6_ready_count", 32'(ready_cnt), 32'd0);
      check("t6_stb_cycles", 32'(stb_cnt), 32'd3);
      check("t6_stb_now", 32'(uart_stb), 32'h0);
      {key_irq, uart_irq, timer_irq} = 3'b000;
      idle_cycles(1);
      timer_irq = 1'b1;
      idle_cycles(1);
      check("t6_hw_int", 32'(hw_int), 32'h01);
      timer_irq = 1'b0;

      // randomized traffic with flushes, garbage inputs and occasional mid-uart resets
      rand_irq = 1;
      for (int t = 0; t < 300; t++) begin
         do_txn(gen_addr(), 1'($urandom), $urandom, int'($urandom_range(1, 20)),
                ($urandom_range(0, 3) == 0),
                ($urandom_range(0, 11) == 0) ? int'($urandom_range(1, 16)) : 0);
         idle_cycles(int'($urandom_range(0, 2)));
      end
      rand_irq = 0;
      idle_cycles(2);

      chk_en = 0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
